// File: rtl/maze_packet_tx.sv
// maze_packet_tx: transmit end of the maze-tile update link.
//
// Packs each accepted tile update into a 16-bit tile word, buffers up to
// FIFO_DEPTH words, and shifts each word out MSB-first on a framed 3-wire
// serial link. The receiver samples SER_DATA on the rising edge of SER_CLK.
//
// Ports:
//   CLK, RESET                  system clock, synchronous active-high reset
//   TILE_X, TILE_Y              tile coordinates (column 0..4, row 0..3)
//   WALLS                       [3] north, [2] east, [1] south, [0] west
//   TREASURE                    treasure code, 0 = none
//   EXPLORED, ROBOT_HERE, DONE  tile / maze status flags
//   IN_VALID, IN_READY          update handshake (push on both high)
//   SER_FRAME                   high for the whole 16-bit frame
//   SER_CLK, SER_DATA           serial bit clock and data, MSB first
//   BUSY                        FIFO non-empty or transmitter active
//
// Tile word: [15:13] X, [12:11] Y, [10:8] treasure, [7] 0,
//            [6] west, [5] north, [4] east, [3] south,
//            [2] explored, [1] robot here, [0] done.

module maze_packet_tx #(
  parameter int CLK_DIV    = 25,  // CLK cycles per SER_CLK half-period, 1..255
  parameter int FIFO_DEPTH = 4,   // power of 2, 2..16
  parameter int GAP_BITS   = 2    // idle bit periods after each frame
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [2:0] TILE_X,
  input  logic [1:0] TILE_Y,
  input  logic [3:0] WALLS,
  input  logic [2:0] TREASURE,
  input  logic       EXPLORED,
  input  logic       ROBOT_HERE,
  input  logic       DONE,
  input  logic       IN_VALID,
  output logic       IN_READY,
  output logic       SER_FRAME,
  output logic       SER_CLK,
  output logic       SER_DATA,
  output logic       BUSY
);

  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = AW + 1;
  // With no gap bits the GAP state still takes one cycle.
  localparam int GAP_CYC = (GAP_BITS == 0) ? 1 : GAP_BITS * 2 * CLK_DIV;
  localparam int GW      = $clog2(GAP_CYC + 1);

  typedef enum logic [1:0] {IDLE, BIT_LO, BIT_HI, GAP} state_e;

  state_e          state_q, state_d;
  logic [15:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            rdy_q, rdy_d;
  logic [14:0]     shift_q, shift_d;    // bits still to send after SER_DATA
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      div_q, div_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            frame_q, frame_d;
  logic            sclk_q, sclk_d;
  logic            sdata_q, sdata_d;

  logic [15:0]     in_word;
  logic            push, pop, div_last, gap_last;

  assign in_word = {TILE_X, TILE_Y, TREASURE, 1'b0,
                    WALLS[0], WALLS[3], WALLS[2], WALLS[1],
                    EXPLORED, ROBOT_HERE, DONE};

  assign push     = IN_VALID && rdy_q;
  // The transmitter only takes a new word while sitting in IDLE.
  assign pop      = (state_q == IDLE) && (count_q != '0);
  assign div_last = (div_q == 8'(CLK_DIV - 1));
  assign gap_last = (gap_q == GW'(GAP_CYC - 1));

  // NOTE: the FIFO storage has no reset; the pointers and count define which
  // entries are valid, so clearing the array would only cost logic.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_word;
    end
  end

  // NOTE: every signal written here gets its default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    div_d     = div_q;
    gap_d     = gap_q;
    frame_d   = frame_q;
    sclk_d    = sclk_q;
    sdata_d   = sdata_q;

    wr_ptr_d  = wr_ptr_q + AW'(push);
    rd_ptr_d  = rd_ptr_q + AW'(pop);
    count_d   = count_q + CW'(push) - CW'(pop);
    // Ready is registered from the next count, so it tracks the count exactly.
    rdy_d     = (count_d != CW'(FIFO_DEPTH));

    unique case (state_q)
      IDLE: begin
        if (pop) begin
          shift_d   = mem_q[rd_ptr_q][14:0];
          sdata_d   = mem_q[rd_ptr_q][15];
          bit_cnt_d = 4'd15;
          frame_d   = 1'b1;
          sclk_d    = 1'b0;
          div_d     = '0;
          state_d   = BIT_LO;
        end
      end
      BIT_LO: begin
        if (div_last) begin
          div_d   = '0;
          sclk_d  = 1'b1;
          state_d = BIT_HI;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      BIT_HI: begin
        if (div_last) begin
          div_d  = '0;
          sclk_d = 1'b0;
          if (bit_cnt_q != 4'd0) begin
            sdata_d   = shift_q[14];
            shift_d   = {shift_q[13:0], 1'b0};
            bit_cnt_d = bit_cnt_q - 4'd1;
            state_d   = BIT_LO;
          end else begin
            sdata_d = 1'b0;
            frame_d = 1'b0;
            gap_d   = '0;
            state_d = GAP;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      GAP: begin
        if (gap_last) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: registers are updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rdy_q     <= 1'b1;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      div_q     <= '0;
      gap_q     <= '0;
      frame_q   <= 1'b0;
      sclk_q    <= 1'b0;
      sdata_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rdy_q     <= rdy_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      div_q     <= div_d;
      gap_q     <= gap_d;
      frame_q   <= frame_d;
      sclk_q    <= sclk_d;
      sdata_q   <= sdata_d;
    end
  end

  assign IN_READY  = rdy_q;
  assign SER_FRAME = frame_q;
  assign SER_CLK   = sclk_q;
  assign SER_DATA  = sdata_q;
  assign BUSY      = (count_q != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_maze_packet_tx.sv
// Self-checking bench for maze_packet_tx. Two instances share the input
// stimulus: u_dut2 (CLK_DIV=2) carries most checks, u_dut3 (CLK_DIV=3) is
// used for frame spacing. A negedge monitor decodes the serial link.

module tb_maze_packet_tx;

  logic       clk;
  logic       rst;
  logic [2:0] tile_x;
  logic [1:0] tile_y;
  logic [3:0] walls;
  logic [2:0] treasure;
  logic       explored, robot_here, done_f, in_valid;
  logic       rdy2, frame2, sclk2, sdata2, busy2;
  logic       rdy3, frame3, sclk3, sdata3, busy3;

  int checks = 0;
  int errors = 0;

  maze_packet_tx #(.CLK_DIV(2), .FIFO_DEPTH(4), .GAP_BITS(2)) u_dut2 (
    .CLK(clk), .RESET(rst), .TILE_X(tile_x), .TILE_Y(tile_y), .WALLS(walls),
    .TREASURE(treasure), .EXPLORED(explored), .ROBOT_HERE(robot_here),
    .DONE(done_f), .IN_VALID(in_valid), .IN_READY(rdy2), .SER_FRAME(frame2),
    .SER_CLK(sclk2), .SER_DATA(sdata2), .BUSY(busy2)
  );

  maze_packet_tx #(.CLK_DIV(3), .FIFO_DEPTH(4), .GAP_BITS(2)) u_dut3 (
    .CLK(clk), .RESET(rst), .TILE_X(tile_x), .TILE_Y(tile_y), .WALLS(walls),
    .TREASURE(treasure), .EXPLORED(explored), .ROBOT_HERE(robot_here),
    .DONE(done_f), .IN_VALID(in_valid), .IN_READY(rdy3), .SER_FRAME(frame3),
    .SER_CLK(sclk3), .SER_DATA(sdata3), .BUSY(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- serial monitor (samples on the falling CLK edge) -------
  int          ncyc = 0;
  int          rise2[$], rise3[$], flen_q[$], hiw_q[$];
  logic [15:0] rx[$];
  logic [15:0] sh = '0;
  int          nbits = 0, flen = 0, hiw = 0, idle_bad3 = 0;
  logic        f2_p = 1'b0, sc2_p = 1'b0, f3_p = 1'b0;

  always @(negedge clk) begin
    ncyc++;
    if (frame2 === 1'b1 && f2_p === 1'b0) begin
      rise2.push_back(ncyc);
      flen  = 0;
      nbits = 0;
    end
    if (frame2 === 1'b1) flen++;
    if (frame2 === 1'b0 && f2_p === 1'b1) begin
      flen_q.push_back(flen);
      if (nbits == 16) rx.push_back(sh);
      nbits = 0;
    end
    if (sclk2 === 1'b1 && sc2_p === 1'b0 && frame2 === 1'b1) begin
      sh = {sh[14:0], sdata2};
      nbits++;
    end
    if (sclk2 === 1'b1) hiw++;
    if (sclk2 === 1'b0 && sc2_p === 1'b1) begin
      hiw_q.push_back(hiw);
      hiw = 0;
    end
    if (frame3 === 1'b1 && f3_p === 1'b0) rise3.push_back(ncyc);
    if (frame3 === 1'b0 && (sclk3 !== 1'b0 || sdata3 !== 1'b0)) idle_bad3++;
    f2_p  = frame2;
    sc2_p = sclk2;
    f3_p  = frame3;
  end

  // ---------------- helpers ------------------------------------------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    rise2.delete(); rise3.delete(); flen_q.delete(); hiw_q.delete(); rx.delete();
    idle_bad3 = 0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_mon();
  endtask

  task automatic set_fields(input logic [2:0] x, input logic [1:0] y, input logic [3:0] w,
                            input logic [2:0] t, input logic e, input logic r, input logic d);
    tile_x = x; tile_y = y; walls = w; treasure = t;
    explored = e; robot_here = r; done_f = d;
  endtask

  task automatic push_one();
    int n = 0;
    in_valid = 1'b1;
    while (!rdy2 && n < 1000) begin
      tick();
      n++;
    end
    check("push_ready", rdy2, 1'b1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_rx(input int n_words, input int budget);
    int n = 0;
    while (rx.size() < n_words && n < budget) begin
      tick();
      n++;
    end
    check("rx_count", rx.size(), n_words);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus -----------------------------------------------
  logic [15:0] walk_exp [10];
  logic [15:0] bp_exp   [8];
  int          ready_hist [0:400];
  int          push_cyc [8];

  initial begin
    int bad, k, n, wait_n;
    logic acc;

    walk_exp = '{16'h0040, 16'h0020, 16'h0010, 16'h0008, 16'h0002,
                 16'h0001, 16'hE000, 16'h1800, 16'h0004, 16'h0700};
    bp_exp   = '{16'h0700, 16'h2600, 16'h4500, 16'h6400,
                 16'h8300, 16'hA200, 16'hC100, 16'hE000};

    set_fields(0, 0, 0, 0, 0, 0, 0);
    do_reset();

    // Reset state
    check("rst_ready", rdy2, 1'b1);
    check("rst_busy",  busy2, 1'b0);
    check("rst_frame", frame2, 1'b0);
    check("rst_sclk",  sclk2, 1'b0);
    check("rst_sdata", sdata2, 1'b0);

    // Packing and serial timing: expected word 0x9564
    set_fields(3'd4, 2'd2, 4'b1001, 3'd5, 1'b1, 1'b0, 1'b0);
    in_valid = 1'b1;
    tick();                          // push edge
    in_valid = 1'b0;
    check("lat_push_edge", frame2, 1'b0);
    tick();                          // pop edge, frame starts
    check("lat_frame_up", frame2, 1'b1);
    check("first_bit", sdata2, 1'b1);
    check("busy_tx", busy2, 1'b1);
    wait_rx(1, 200);
    if (rx.size() >= 1) check("pack_word", rx[0], 16'h9564);
    if (flen_q.size() >= 1) check("frame_len", flen_q[0], 64);
    check("sclk_pulses", hiw_q.size(), 16);
    bad = 0;
    foreach (hiw_q[i]) if (hiw_q[i] != 2) bad++;
    check("sclk_hi_width", bad, 0);
    repeat (12) tick();
    check("busy_idle", busy2, 1'b0);

    // Bit mapping: one field bit set per word
    do_reset();
    for (int i = 0; i < 10; i++) begin
      case (i)
        0: set_fields(0, 0, 4'b0001, 0, 0, 0, 0);
        1: set_fields(0, 0, 4'b1000, 0, 0, 0, 0);
        2: set_fields(0, 0, 4'b0100, 0, 0, 0, 0);
        3: set_fields(0, 0, 4'b0010, 0, 0, 0, 0);
        4: set_fields(0, 0, 4'b0000, 0, 0, 1, 0);
        5: set_fields(0, 0, 4'b0000, 0, 0, 0, 1);
        6: set_fields(7, 0, 4'b0000, 0, 0, 0, 0);
        7: set_fields(0, 3, 4'b0000, 0, 0, 0, 0);
        8: set_fields(0, 0, 4'b0000, 0, 1, 0, 0);
        default: set_fields(0, 0, 4'b0000, 7, 0, 0, 0);
      endcase
      push_one();
    end
    wait_rx(10, 1500);
    for (int i = 0; i < 10; i++)
      if (i < rx.size()) check($sformatf("walk_%0d", i), rx[i], walk_exp[i]);

    // Back-pressure, plus the push/pop collision when full in IDLE
    do_reset();
    k = 0;
    n = 0;
    set_fields(3'd0, 0, 0, 3'd7, 0, 0, 0);
    in_valid = 1'b1;
    while (k < 8 && n < 400) begin
      acc = rdy2;
      tick();
      n++;
      ready_hist[n] = rdy2;
      if (acc) begin
        push_cyc[k] = n;
        k++;
        if (k < 8) set_fields(3'(k), 0, 0, 3'(7 - k), 0, 0, 0);
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check("bp_all_pushed", k, 8);
    for (int i = 0; i < 5; i++) check($sformatf("bp_push_%0d", i), push_cyc[i], i + 1);
    check("bp_ready_before_full", ready_hist[4], 1);
    check("bp_ready_full",        ready_hist[5], 0);
    check("bp_ready_pre_pop",     ready_hist[74], 0);
    check("bp_ready_after_pop",   ready_hist[75], 1);
    check("bp_push_5", push_cyc[5], 76);
    check("bp_push_6", push_cyc[6], 149);
    check("bp_push_7", push_cyc[7], 222);
    wait_rx(8, 800);
    for (int i = 0; i < 8; i++)
      if (i < rx.size()) check($sformatf("bp_word_%0d", i), rx[i], bp_exp[i]);

    // Frame spacing on the CLK_DIV=3 instance
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_fields(3'(i + 1), 2'd1, 4'b0101, 3'd2, 1'b1, 0, 0);
      push_one();
    end
    wait_n = 0;
    while (rise3.size() < 3 && wait_n < 600) begin
      tick();
      wait_n++;
    end
    repeat (130) tick();
    check("sp_frames", rise3.size(), 3);
    if (rise3.size() >= 3) begin
      check("sp_gap_01", rise3[1] - rise3[0], 109);
      check("sp_gap_12", rise3[2] - rise3[1], 109);
    end
    if (rise2.size() >= 2) check("sp_gap_div2", rise2[1] - rise2[0], 73);
    check("sp_idle_quiet", idle_bad3, 0);

    // Reset in the middle of a frame with two words queued behind it
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_fields(3'd2, 2'd3, 4'b1111, 3'(i), 0, 0, 0);
      push_one();
    end
    repeat (32) tick();              // now inside bit 7 of the first frame
    check("mid_in_frame", frame2, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_mon();
    check("mid_frame", frame2, 1'b0);
    check("mid_sclk",  sclk2, 1'b0);
    check("mid_sdata", sdata2, 1'b0);
    check("mid_ready", rdy2, 1'b1);
    check("mid_busy",  busy2, 1'b0);
    repeat (300) tick();
    check("mid_no_frames", rise2.size(), 0);
    check("mid_no_words",  rx.size(), 0);
    set_fields(3'd3, 2'd1, 4'b0110, 3'd6, 1'b0, 1'b1, 1'b1);
    push_one();
    wait_rx(1, 200);
    if (rx.size() >= 1) check("mid_new_word", rx[0], 16'h6E1B);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/maze_packet_tx.md
Name: maze_packet_tx

Overview:
- Transmit end of the maze-tile update link. Accepts tile updates from robot/navigation logic through a valid/ready handshake.
- Packs each update into the 16-bit tile word that the VGA maze display consumes as DATA_IN/DATA_VAL.
- Buffers up to FIFO_DEPTH words and shifts each one out MSB-first on a 3-wire framed serial link (SER_FRAME, SER_CLK, SER_DATA) to the display board.

Parameters:
- CLK_DIV, 25: CLK cycles per SER_CLK half-period; legal range 1..255.
- FIFO_DEPTH, 4: number of packed words buffered; must be a power of 2, 2..16.
- GAP_BITS, 2: idle bit periods (2*CLK_DIV cycles each) inserted after every frame.

Ports:
- CLK, input, 1: system clock, 50 MHz.
- RESET, input, 1: synchronous, active-high reset.
- TILE_X, input, 3: tile column, 0..4.
- TILE_Y, input, 2: tile row, 0..3.
- WALLS, input, 4: [3] north, [2] east, [1] south, [0] west.
- TREASURE, input, 3: treasure code, 0 = none.
- EXPLORED, input, 1: tile previously visited.
- ROBOT_HERE, input, 1: robot currently on this tile.
- DONE, input, 1: maze complete.
- IN_VALID, input, 1: update fields are valid.
- IN_READY, output, 1: FIFO can accept an update.
- SER_FRAME, output, 1: high for the duration of a 16-bit frame.
- SER_CLK, output, 1: serial bit clock; the receiver samples on its rising edge.
- SER_DATA, output, 1: serial data, MSB first.
- BUSY, output, 1: FIFO non-empty or FSM not in IDLE.

Behaviour:
- Clock and reset: one clock, CLK. RESET is synchronous and active-high. On a reset edge the FIFO empties, the FSM goes to IDLE, SER_FRAME/SER_CLK/SER_DATA/BUSY become 0, and IN_READY becomes 1. This applies equally mid-frame; the partial frame is abandoned and the receiver discards frames shorter than 16 bits.
- Packing happens at push time and is combinational from the inputs:
  - [15:13] TILE_X; [12:11] TILE_Y; [10:8] TREASURE; [7] 0.
  - [6] west; [5] north; [4] east; [3] south.
  - [2] EXPLORED; [1] ROBOT_HERE; [0] DONE.
- FIFO:
  - A push occurs when IN_VALID && IN_READY at a rising edge. IN_READY = !full, registered from the count.
  - A pop occurs only from IDLE when the FIFO is non-empty.
  - A push and a pop in the same cycle leaves the count unchanged.
  - The count width is log2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.
  - IN_VALID while full is ignored: no push, no overflow corruption. The producer must hold its data.
- FSM states: IDLE, BIT_LO, BIT_HI, GAP.
  - IDLE -> BIT_LO when the FIFO is non-empty. On that edge: shift register <= head word, bit counter <= 15, SER_FRAME <= 1, SER_DATA <= bit 15, SER_CLK <= 0, divider <= 0.
  - BIT_LO: after CLK_DIV cycles, set SER_CLK <= 1 and go to BIT_HI. SER_DATA is stable for the whole low phase (setup = CLK_DIV cycles).
  - BIT_HI, after CLK_DIV cycles:
    - If bit counter > 0: SER_CLK <= 0, shift left, SER_DATA <= next bit, decrement counter, go to BIT_LO.
    - If counter == 0: SER_CLK <= 0, SER_DATA <= 0, SER_FRAME <= 0, go to GAP.
  - GAP: hold all serial outputs at 0 for GAP_BITS*2*CLK_DIV cycles, then go to IDLE. With GAP_BITS = 0, GAP lasts exactly 1 cycle.
- Timing:
  - An update pushed into an empty FIFO at edge t appears as SER_FRAME high after edge t+1 (2-cycle latency).
  - SER_FRAME stays high for exactly 32*CLK_DIV cycles.
  - Frame-to-frame period = (32 + 2*GAP_BITS)*CLK_DIV + 1 cycles, with the +1 for the IDLE pop cycle.
- The divider counts 0..CLK_DIV-1 with no 8-bit overflow; CLK_DIV = 1 gives SER_CLK = CLK/2.
- Inputs may change freely after a push; the packed word is captured at push.

Test Plan:
- Packing and serial timing: CLK_DIV=2, GAP_BITS=2; push X=4, Y=2, WALLS=4'b1001, TREASURE=5, EXPLORED=1, others 0.
  - Expected: SER_FRAME rises 2 cycles after the push and stays high 64 cycles.
  - A rising-edge sampler recovers 0x9564; the 16 SER_CLK pulses are each 2 cycles high.
- Bit mapping: walk a single 1 through each input field (WALLS[0..3], ROBOT_HERE, DONE, TILE_X=7, TILE_Y=3).
  - Expected words: 0x0040, 0x0020, 0x0010, 0x0008, 0x0002, 0x0001, 0xE000, 0x1800. Bit 7 is always 0.
- Back-pressure: FIFO_DEPTH=4; hold IN_VALID high with 8 distinct words.
  - Expected: 5 words are accepted back-to-back, then IN_READY falls.
  - IN_READY rises the cycle after each subsequent pop; all 8 words arrive in order with no loss or duplication.
- Frame spacing: CLK_DIV=3, GAP_BITS=2; queue 3 words.
  - Expected: consecutive SER_FRAME rising edges are exactly 109 cycles apart; SER_DATA and SER_CLK are 0 between frames.
- Reset mid-frame: assert RESET for 1 cycle during bit 7 of a frame with 2 words queued.
  - Expected: all serial outputs are 0 on the next edge and IN_READY=1, BUSY=0.
  - No further frames are emitted; a new push then transmits normally.
- Simultaneous push/pop at the boundary: FIFO full and in IDLE with IN_VALID high.
  - Expected: the pop that cycle leaves the count at 3, IN_READY=1 the next cycle, and the push lands in the freed slot with correct wrap-around order.
